if_id_skid_reg: RTL

- Parametrised IF/ID-style pipeline stage register with a valid/ready handshake and a 2-entry skid buffer.
- Replaces the stall-only stage register: backpressure is absorbed without a combinational ready path from the downstream stage.
- Supports flush with NOP bubble insertion and saturating stall/flush event counters for performance debug.
- Sits between the fetch stage (upstream) and the decode stage (downstream).

---
 rtl/if_id_skid_reg.sv | 136 +++++++++++++
 1 files changed

// File: rtl/if_id_skid_reg.sv
// IF/ID stage register with a valid/ready handshake and a 2-entry skid buffer.
// in_ready_o comes straight from the state register; flush inserts NOP bubbles.
module if_id_skid_reg #(
    parameter int unsigned PC_W          = 32,
    parameter int unsigned DATA_W        = 32,
    parameter logic [DATA_W-1:0] NOP_VAL = '0,
    parameter bit          FLUSH_KEEP_PC = 1'b1,
    parameter int unsigned CNT_W         = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [PC_W-1:0]   pc_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [PC_W-1:0]   pc_o,
    output logic [DATA_W-1:0] data_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  flush_cnt_o
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t            state_q, state_d;
    logic [PC_W-1:0]   main_pc_q, main_pc_d;
    logic [PC_W-1:0]   skid_pc_q, skid_pc_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
    logic              accept, drain;

    assign in_ready_o  = (state_q != SKID);
    assign out_valid_o = (state_q != EMPTY);
    assign accept      = in_valid_i & in_ready_o;
    assign drain       = out_valid_o & out_ready_i;

    // main_data_q is forced to NOP_VAL on every path into EMPTY
    assign pc_o        = main_pc_q;
    assign data_o      = main_data_q;
    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;

    always_comb begin
        state_d     = state_q;
        main_pc_d   = main_pc_q;
        main_data_d = main_data_q;
        skid_pc_d   = skid_pc_q;
        skid_data_d = skid_data_q;
        if (flush_i) begin
            state_d     = EMPTY;
            main_data_d = NOP_VAL;
            skid_data_d = NOP_VAL;
            if (!FLUSH_KEEP_PC) begin
                main_pc_d = '0;
                skid_pc_d = '0;
            end
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_d     = FULL;
                        main_pc_d   = pc_i;
                        main_data_d = data_i;
                    end
                end
                FULL: begin
                    if (accept && drain) begin
                        main_pc_d   = pc_i;
                        main_data_d = data_i;
                    end else if (drain) begin
                        state_d     = EMPTY;
                        main_data_d = NOP_VAL;
                    end else if (accept) begin
                        state_d     = SKID;
                        skid_pc_d   = pc_i;
                        skid_data_d = data_i;
                    end
                end
                SKID: begin
                    if (drain) begin
                        state_d     = FULL;
                        main_pc_d   = skid_pc_q;
                        main_data_d = skid_data_q;
                    end
                end
                default: begin
                    state_d     = EMPTY;
                    main_data_d = NOP_VAL;
                end
            endcase
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (out_valid_o && !out_ready_i && !flush_i && stall_cnt_q != CNT_MAX) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end
        if (flush_i && flush_cnt_q != CNT_MAX) begin
            flush_cnt_d = flush_cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= EMPTY;
            main_pc_q   <= '0;
            skid_pc_q   <= '0;
            main_data_q <= NOP_VAL;
            skid_data_q <= NOP_VAL;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            main_pc_q   <= main_pc_d;
            skid_pc_q   <= skid_pc_d;
            main_data_q <= main_data_d;
            skid_data_q <= skid_data_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

endmodule
